mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte-addressable scratch memory with sized loads/stores,
// a one-cycle registered load path, and a word-per-cycle full-memory clear.
//
// Optional feature: define MEM_MISALIGN_TRAP_EN to add the o_misalign output.
// With it, misaligned half/word accesses are trapped and suppressed. Without
// it, the low address bits below the access size are simply ignored.
module mem_access_unit #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 32
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     i_valid,
  input  logic                     MemWrite,
  input  logic                     MemRead,
  input  logic [1:0]               ByteSig,
  input  logic                     i_unsigned,
  input  logic [ADDR_W-1:0]        ALUResult,
  input  logic [DATA_W-1:0]        RegRTData,
  input  logic                     i_flush,
  output logic                     o_busy,
  output logic                     o_rd_valid,
  output logic [DATA_W-1:0]        MemReadData,
  output logic [DATA_W*DEPTH-1:0]  o_bus_debug
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic                     o_misalign
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int LANES = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state, state_n;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  flush_cnt;

  // Request decode
  logic              accept;
  logic              is_store;
  logic              is_load;
  logic              store_en;
  logic              load_en;
  logic [IDX_W-1:0]  req_idx;
  logic [1:0]        req_lane;

  // Store lane enables and lane-replicated store data
  logic [LANES-1:0]  wr_be;
  logic [DATA_W-1:0] wr_data;

  // Load request captured at acceptance and completed in the READ cycle
  logic [IDX_W-1:0]  rd_idx;
  logic [1:0]        rd_lane;
  logic [1:0]        rd_size;
  logic              rd_uns;
  logic [DATA_W-1:0] rd_word;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [DATA_W-1:0] load_ext;

  // Address bits above the word index only wrap the address space.
  logic              unused_addr_hi;
  assign unused_addr_hi = ^ALUResult[ADDR_W-1:IDX_W+2];

  assign o_busy   = (state == FLUSH);
  // A flush request wins over any access presented in the same cycle.
  assign accept   = i_valid & ~o_busy & ~i_flush;
  assign is_store = accept & MemWrite;
  assign is_load  = accept & MemRead & ~MemWrite;
  assign req_idx  = ALUResult[IDX_W+1:2];
  assign req_lane = ALUResult[1:0];

`ifdef MEM_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = (ByteSig == 2'b01) ? ALUResult[0]
                                         : (ByteSig[1] & (ALUResult[1:0] != 2'b00));
  assign store_en   = is_store & ~misaligned;
  assign load_en    = is_load & ~misaligned;
`else
  assign store_en   = is_store;
  assign load_en    = is_load;
`endif

  // Store lane selection: byte picks one lane, half picks a lane pair within
  // the low 32 bits, word writes every lane.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned, which is what would otherwise infer a latch.
    wr_be   = '0;
    wr_data = '0;
    for (int l = 0; l < LANES; l++) begin
      case (ByteSig)
        2'b00: begin
          wr_be[l]          = (l == int'(req_lane));
          wr_data[8*l +: 8] = RegRTData[7:0];
        end
        2'b01: begin
          wr_be[l]          = (l < 4) && ((l / 2) == int'(req_lane[1]));
          wr_data[8*l +: 8] = RegRTData[8*(l%2) +: 8];
        end
        default: begin
          wr_be[l]          = 1'b1;
          wr_data[8*l +: 8] = RegRTData[8*l +: 8];
        end
      endcase
    end
  end

  // Memory array: cleared by reset, cleared one word per FLUSH cycle,
  // otherwise updated lane-wise by accepted stores.
  always_ff @(posedge Clock or posedge Reset) begin
    // NOTE: the memory itself is reset here because reset must zero every
    // word; a plain RAM macro would not allow this, registers do.
    if (Reset) begin
      for (int w = 0; w < DEPTH; w++) begin
        mem[w] <= '0;
      end
    end else if (state == FLUSH) begin
      mem[flush_cnt] <= '0;
    end else if (store_en) begin
      for (int l = 0; l < LANES; l++) begin
        if (wr_be[l]) begin
          mem[req_idx][8*l +: 8] <= wr_data[8*l +: 8];
        end
      end
    end
  end

  // State register and flush word counter.
  always_ff @(posedge Clock or posedge Reset) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of block ordering.
    if (Reset) begin
      state     <= IDLE;
      flush_cnt <= '0;
    end else begin
      state     <= state_n;
      if (state == FLUSH) begin
        flush_cnt <= flush_cnt + 1'b1;
      end else begin
        flush_cnt <= '0;
      end
    end
  end

  // Next-state logic: a load always lands in READ (back-to-back allowed),
  // flush is entered from IDLE/READ and ignored while already flushing.
  always_comb begin
    state_n = state;
    case (state)
      IDLE, READ: begin
        if (i_flush) begin
          state_n = FLUSH;
        end else if (load_en) begin
          state_n = READ;
        end else begin
          state_n = IDLE;
        end
      end
      FLUSH: begin
        if (flush_cnt == IDX_W'(DEPTH - 1)) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Capture load size, lane and extension mode at acceptance.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rd_idx  <= '0;
      rd_lane <= '0;
      rd_size <= '0;
      rd_uns  <= 1'b0;
    end else if (load_en) begin
      rd_idx  <= req_idx;
      rd_lane <= req_lane;
      rd_size <= ByteSig;
      rd_uns  <= i_unsigned;
    end
  end

  // Select the addressed field of the pending word and extend it to DATA_W.
  always_comb begin
    rd_word  = mem[rd_idx];
    rd_byte  = rd_word[{rd_lane, 3'b000} +: 8];
    rd_half  = rd_word[{rd_lane[1], 4'b0000} +: 16];
    load_ext = rd_word;
    case (rd_size)
      2'b00:   load_ext = {{(DATA_W-8){~rd_uns & rd_byte[7]}}, rd_byte};
      2'b01:   load_ext = {{(DATA_W-16){~rd_uns & rd_half[15]}}, rd_half};
      default: load_ext = rd_word;
    endcase
  end

  // Load result register: fresh for one cycle after READ, held otherwise.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      o_rd_valid  <= 1'b0;
      MemReadData <= '0;
    end else begin
      o_rd_valid <= (state == READ);
      if (state == READ) begin
        MemReadData <= load_ext;
      end
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  // One-cycle trap pulse after a misaligned accepted access.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      o_misalign <= 1'b0;
    end else begin
      o_misalign <= accept & (MemWrite | MemRead) & misaligned;
    end
  end
`endif

  // Debug view of the whole array, word 0 in the least significant bits.
  always_comb begin
    o_bus_debug = '0;
    for (int w = 0; w < DEPTH; w++) begin
      o_bus_debug[DATA_W*w +: DATA_W] = mem[w];
    end
  end

endmodule
